// File: rtl/bus_copy_master.sv
// Bus-master block copy engine: reads each word from the source range and writes it
// to the destination range through one master port of the shared two-master bus.
module bus_copy_master #(
    parameter int LEN_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [7:0]       src_addr,
    input  logic [7:0]       dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             M_req,
    input  logic             M_grant,
    output logic             M_wr,
    output logic [7:0]       M_address,
    output logic [31:0]      M_dout,
    input  logic [31:0]      M_din
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_READ  = 3'd2,
        ST_RDATA = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_s;
    logic [7:0]       src_r;
    logic [7:0]       src_s;
    logic [7:0]       dst_r;
    logic [7:0]       dst_s;
    logic [LEN_W-1:0] cnt_r;
    logic [LEN_W-1:0] cnt_s;
    logic [31:0]      data_r;
    logic [31:0]      data_s;
    logic             wr_r;

    // Next-state and datapath update; grant loss freezes the transfer in place.
    always_comb begin
        state_s = state_r;
        src_s   = src_r;
        dst_s   = dst_r;
        cnt_s   = cnt_r;
        data_s  = data_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (len == CNT_ZERO) begin
                        state_s = ST_DONE;
                    end else begin
                        src_s   = src_addr;
                        dst_s   = dst_addr;
                        cnt_s   = len;
                        state_s = ST_REQ;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (M_grant) begin
                    state_s = ST_READ;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_READ: begin
                if (M_grant) begin
                    state_s = ST_RDATA;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_RDATA: begin
                // Without grant the returning data is not trusted, so the read is reissued.
                if (M_grant) begin
                    data_s  = M_din;
                    state_s = ST_WRITE;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_WRITE: begin
                if (M_grant) begin
                    src_s = src_r + 8'd1;
                    dst_s = dst_r + 8'd1;
                    cnt_s = cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_READ;
                    end
                end else begin
                    state_s = ST_WRITE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers; outputs are decoded from the next state
    // so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            src_r     <= 8'd0;
            dst_r     <= 8'd0;
            cnt_r     <= CNT_ZERO;
            data_r    <= 32'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            M_req     <= 1'b0;
            wr_r      <= 1'b0;
            M_address <= 8'd0;
            M_dout    <= 32'd0;
        end else begin
            state_r <= state_s;
            src_r   <= src_s;
            dst_r   <= dst_s;
            cnt_r   <= cnt_s;
            data_r  <= data_s;
            busy    <= (state_s != ST_IDLE);
            done    <= (state_s == ST_DONE);
            M_req   <= (state_s inside {ST_REQ, ST_READ, ST_RDATA, ST_WRITE});
            wr_r    <= (state_s == ST_WRITE);
            case (state_s)
                ST_READ, ST_RDATA: begin
                    M_address <= src_s;
                    M_dout    <= 32'd0;
                end
                ST_WRITE: begin
                    M_address <= dst_s;
                    M_dout    <= data_s;
                end
                default: begin
                    M_address <= 8'd0;
                    M_dout    <= 32'd0;
                end
            endcase
        end
    end

    // A write strobe must never reach the bus while another master owns it.
    assign M_wr = wr_r & M_grant;

endmodule

// File: tb/tb_bus_copy_master.sv
// Directed bench for bus_copy_master: a registered-read word memory stands in for the
// bus slave, and the grant input is driven directly to emulate arbitration.
module tb_bus_copy_master;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [7:0]  src_addr;
    logic [7:0]  dst_addr;
    logic [4:0]  len;
    logic        busy;
    logic        done;
    logic        M_req;
    logic        M_grant;
    logic        M_wr;
    logic [7:0]  M_address;
    logic [31:0] M_dout;
    logic [31:0] M_din;

    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [31:0] pl_data;
    logic [31:0] mem  [0:255];
    logic [31:0] gold [0:255];

    int n_cmp;
    int n_bad;

    bus_copy_master #(.LEN_W(5)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .M_req     (M_req),
        .M_grant   (M_grant),
        .M_wr      (M_wr),
        .M_address (M_address),
        .M_dout    (M_dout),
        .M_din     (M_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave memory: read data is registered, so it appears one cycle after the address.
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (M_wr) begin
            mem[M_address] <= M_dout;
        end
        M_din <= mem[M_address];
    end

    function automatic logic [63:0] exp_v(input logic b, input logic d, input logic r,
                                          input logic w, input logic [7:0] a,
                                          input logic [31:0] dt);
        return {20'd0, b, d, r, w, a, dt};
    endfunction

    function automatic logic [63:0] bus_v();
        return {20'd0, busy, done, M_req, M_wr, M_address, M_dout};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] v);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = v;
        gold[a] = v;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Full copy with a cycle-accurate trace check; grant is withheld for the first
    // `hold` cycles and a stray start is pulsed at cycle `rs` (0 = none).
    task automatic do_copy(input logic [7:0] s, input logic [7:0] d, input int n,
                           input int hold, input int rs);
        int last;
        last     = hold + 3 * n + 2;
        src_addr = s;
        dst_addr = d;
        len      = n[4:0];
        start    = 1'b1;
        if (hold > 0) M_grant = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= last + 1; c++) begin
            int          cp;
            int          k;
            int          ph;
            logic [7:0]  a;
            logic [63:0] e;
            cp = c - hold;
            if (cp <= 1) begin
                e = exp_v(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 32'd0);
            end else if (c < last) begin
                k  = (cp - 2) / 3;
                ph = (cp - 2) % 3;
                if (ph < 2) begin
                    a = s + 8'(k);
                    e = exp_v(1'b1, 1'b0, 1'b1, 1'b0, a, 32'd0);
                end else begin
                    a = s + 8'(k);
                    e = exp_v(1'b1, 1'b0, 1'b1, 1'b1, d + 8'(k), gold[a]);
                end
            end else if (c == last) begin
                e = exp_v(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 32'd0);
            end else begin
                e = 64'd0;
            end
            chk($sformatf("copy s=%0h c=%0d", s, c), bus_v(), e);
            M_grant = (c > hold);
            start   = (c == rs);
            if (c == rs) begin
                src_addr = 8'h00;
                dst_addr = 8'h20;
                len      = 5'd9;
            end
            @(negedge clk);
        end
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            logic [7:0] sa;
            logic [7:0] da;
            sa = s + 8'(k);
            da = d + 8'(k);
            chk($sformatf("mem %0h", da), {32'd0, mem[da]}, {32'd0, gold[sa]});
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        src_addr = 8'h00;
        dst_addr = 8'h00;
        len      = 5'd0;
        M_grant  = 1'b0;
        pl_en    = 1'b0;
        pl_addr  = 8'h00;
        pl_data  = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset", bus_v(), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle", bus_v(), 64'd0);

        preload(8'h20, 32'h11111111);
        preload(8'h21, 32'h22222222);
        preload(8'h22, 32'h33333333);
        preload(8'h23, 32'h44444444);
        preload(8'hFE, 32'hA5A500FE);
        preload(8'hFF, 32'h5A5A00FF);
        preload(8'h00, 32'hC3C30000);

        // Basic 4-word copy, grant already held.
        M_grant = 1'b1;
        do_copy(8'h20, 8'h40, 4, 0, 0);

        // Zero length: straight to DONE, no bus request.
        src_addr = 8'h20;
        dst_addr = 8'h40;
        len      = 5'd0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("len0 done", bus_v(), exp_v(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 32'd0));
        @(negedge clk);
        chk("len0 idle", bus_v(), 64'd0);

        // Other master owns the bus for 5 cycles.
        do_copy(8'h22, 8'h70, 2, 5, 0);

        // Address wrap, plus a start pulsed during the DONE cycle.
        do_copy(8'hFE, 8'h7E, 3, 0, 11);

        // Grant lost during WRITE: strobe drops, write completes after regrant.
        M_grant  = 1'b1;
        src_addr = 8'h22;
        dst_addr = 8'h50;
        len      = 5'd1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("gl write", bus_v(), exp_v(1'b1, 1'b0, 1'b1, 1'b1, 8'h50, 32'h33333333));
        M_grant = 1'b0;
        #1;
        chk("gl wr drop", bus_v(), exp_v(1'b1, 1'b0, 1'b1, 1'b0, 8'h50, 32'h33333333));
        @(negedge clk);
        chk("gl hold", bus_v(), exp_v(1'b1, 1'b0, 1'b1, 1'b0, 8'h50, 32'h33333333));
        M_grant = 1'b1;
        #1;
        chk("gl regrant", bus_v(), exp_v(1'b1, 1'b0, 1'b1, 1'b1, 8'h50, 32'h33333333));
        @(negedge clk);
        chk("gl done", bus_v(), exp_v(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 32'd0));
        @(negedge clk);
        chk("gl idle", bus_v(), 64'd0);
        chk("gl mem", {32'd0, mem[8'h50]}, {32'd0, 32'h33333333});

        // Grant lost during RDATA: read is reissued.
        src_addr = 8'h23;
        dst_addr = 8'h51;
        len      = 5'd1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("rl rdata", bus_v(), exp_v(1'b1, 1'b0, 1'b1, 1'b0, 8'h23, 32'd0));
        M_grant = 1'b0;
        @(negedge clk);
        chk("rl reread", bus_v(), exp_v(1'b1, 1'b0, 1'b1, 1'b0, 8'h23, 32'd0));
        M_grant = 1'b1;
        @(negedge clk);
        chk("rl rdata2", bus_v(), exp_v(1'b1, 1'b0, 1'b1, 1'b0, 8'h23, 32'd0));
        @(negedge clk);
        chk("rl write", bus_v(), exp_v(1'b1, 1'b0, 1'b1, 1'b1, 8'h51, 32'h44444444));
        @(negedge clk);
        chk("rl done", bus_v(), exp_v(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 32'd0));
        @(negedge clk);
        chk("rl idle", bus_v(), 64'd0);
        chk("rl mem", {32'd0, mem[8'h51]}, {32'd0, 32'h44444444});

        // Reset during the WRITE of word 2, then a clean full transfer.
        src_addr = 8'h20;
        dst_addr = 8'h60;
        len      = 5'd4;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst pre", bus_v(), exp_v(1'b1, 1'b0, 1'b1, 1'b1, 8'h61, 32'h22222222));
        reset_n = 1'b0;
        #1;
        chk("rst async", bus_v(), 64'd0);
        @(negedge clk);
        chk("rst held", bus_v(), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst idle", bus_v(), 64'd0);
        do_copy(8'h20, 8'h60, 4, 0, 0);

        // Start pulsed while busy is ignored.
        do_copy(8'h20, 8'h48, 4, 0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_copy_master.md
Name: bus_copy_master

Overview:
- Bus-master engine that copies a block of 32-bit words from one slave address range to another through the shared two-master bus.
- Attaches to either master port (M0 or M1) of the bus, alongside the CPU/testbench master.
- Requests the bus, performs a read-then-write sequence per word, releases the bus, and pulses done.
- Read data timing matches the bus: data for a read address appears on M_din one cycle later, because the bus registers slave select.

Parameters:
- LEN_W, 5, width of the length input; maximum transfer is 2^LEN_W-1 words (31).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; sampled only in IDLE.
- src_addr  input  8  first source word address.
- dst_addr  input  8  first destination word address.
- len  input  LEN_W  number of words to copy.
- busy  output  1  high from the cycle after an accepted start until the done cycle, inclusive.
- done  output  1  one-cycle pulse when the transfer completes.
- M_req  output  1  bus request to the arbiter.
- M_grant  input  1  bus grant from the arbiter.
- M_wr  output  1  1 = write, 0 = read.
- M_address  output  8  bus address.
- M_dout  output  32  write data to the bus.
- M_din  input  32  read data from the bus.

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE; all outputs 0; internal src/dst/count/data registers cleared. Reset mid-transfer aborts immediately, and no further bus cycles are issued.
- Start in IDLE with len=0: go to DONE. M_req is never asserted.
- Start in IDLE with len>0: latch src_addr, dst_addr and len into internal registers, then go to REQ. Start is ignored while busy.
- States:
  - IDLE: all outputs 0.
  - REQ: M_req=1. Go to READ when M_grant=1 is sampled.
  - READ: M_req=1, M_wr=0, M_address=src. Go to RDATA.
  - RDATA: M_req=1, M_wr=0, M_address=src. Capture M_din into the data register. Go to WRITE.
  - WRITE: M_req=1, M_wr=1, M_address=dst, M_dout=data. Then src+1, dst+1, count-1. If the new count is 0, go to DONE; else go to READ.
  - DONE: done=1, busy=1, M_req=0. Go to IDLE.
- M_req stays high continuously from REQ through the last WRITE. Under the arbiter rules, this holds grant for the whole transfer.
- Grant loss: in READ, RDATA or WRITE, if M_grant=0 the FSM holds its state and registers and drives M_wr=0. When grant returns, RDATA is re-entered through READ, so the read is reissued; WRITE resumes as WRITE.
- Addresses increment modulo 256. 0xFF+1 wraps to 0x00, with no error flag.
- Outside READ/RDATA/WRITE, M_wr=0, M_address=0 and M_dout=0.
- Throughput: 3 cycles per word while granted. The total for N words with grant already high is 1 (REQ) + 3N + 1 (DONE).

Test Plan:
- Port as M0, M1 idle; memory A (0x20-0x23) holds 0x11111111..0x44444444; start src=0x20, dst=0x40, len=4 -> M_address sequence 20,20,40,21,21,41..23,23,43; done at cycle 14 after start; memory B 0x40-0x43 equals the source words.
- len=0 -> done pulses 1 cycle after start; M_req, M_wr and busy around done never assert any bus cycle.
- Port as M1 with M0_req held high for 5 cycles -> block stays in REQ with M_req=1 and no M_wr; copy of 2 words completes correctly after M0 releases.
- Wrap: src=0xFE, dst=0x7E, len=3 -> reads FE, FF, 00; writes 7E, 7F, 80; done pulses once.
- Assert reset_n=0 during the WRITE of word 2 of 4 -> outputs 0 immediately; after release the FSM is in IDLE; a new start performs a full transfer correctly.
- Pulse start again while busy -> ignored; exactly one done pulse; registers unaffected.
